// File: rtl/yuv_pkg.sv
// Shared constants and state encoding for the YUV-to-RGB converter.
// Coefficients are BT.601 full-range values in Q8 fixed point.
package yuv_pkg;

  localparam int DW   = 9;
  localparam int FRAC = 8;

  localparam logic signed [9:0]  C_RV = 10'sd359;
  localparam logic signed [9:0]  C_GU = 10'sd88;
  localparam logic signed [9:0]  C_GV = 10'sd183;
  localparam logic signed [9:0]  C_BU = 10'sd454;

  localparam logic [8:0]         OFFSET = 9'd128;
  localparam logic signed [19:0] ROUND  = 20'sd128;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL0 = 3'd1,
    MUL1 = 3'd2,
    MUL2 = 3'd3,
    MUL3 = 3'd4,
    SAT  = 3'd5
  } state_e;

endpackage

// File: rtl/yuv2rgb_if.sv
// Pixel request/result bundle between a pixel source and the converter.
interface yuv2rgb_if;
  import yuv_pkg::*;

  logic          start;
  logic [DW-1:0] Y_in;
  logic [DW-1:0] U_in;
  logic [DW-1:0] V_in;
  logic          done;
  logic [DW-1:0] outR;
  logic [DW-1:0] outG;
  logic [DW-1:0] outB;

  modport master (output start, Y_in, U_in, V_in, input done, outR, outG, outB);
  modport slave  (input start, Y_in, U_in, V_in, output done, outR, outG, outB);

endinterface

// File: rtl/clamp_u8.sv
// Saturates a signed 12-bit intermediate to 0..255, zero-padded to 9 bits.
module clamp_u8 (
  input  logic signed [11:0] val,
  output logic [8:0]         res
);

  always_comb begin
    if (val < 12'sd0) begin
      res = 9'd0;
    end else if (val > 12'sd255) begin
      res = 9'd255;
    end else begin
      res = {1'b0, val[7:0]};
    end
  end

endmodule

// File: rtl/yuv2rgb.sv
// Sequential YUV-to-RGB converter: one shared signed multiplier, four MUL
// cycles, one saturation cycle, then a one-cycle done pulse.
module yuv2rgb
  import yuv_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  yuv2rgb_if.slave  bus
);

  state_e              state_q, state_d;
  logic [7:0]          y_q, y_d;
  logic signed [8:0]   du_q, du_d;
  logic signed [8:0]   dv_q, dv_d;
  logic signed [19:0]  acc_r_q, acc_r_d;
  logic signed [19:0]  acc_g_q, acc_g_d;
  logic signed [19:0]  acc_b_q, acc_b_d;
  logic [8:0]          out_r_q, out_r_d;
  logic [8:0]          out_g_q, out_g_d;
  logic [8:0]          out_b_q, out_b_d;
  logic                done_q, done_d;

  logic signed [8:0]   op;
  logic signed [9:0]   coef;
  logic [18:0]         op_ext, coef_ext;
  logic signed [18:0]  prod;
  logic signed [19:0]  prod_ext;
  logic signed [19:0]  rnd_r, rnd_g, rnd_b;
  logic signed [11:0]  term_r, term_g, term_b;
  logic signed [11:0]  sum_r, sum_g, sum_b;
  logic [8:0]          clamp_r, clamp_g, clamp_b;
  logic                unused_pad;

  assign unused_pad = ^{bus.Y_in[8], bus.U_in[8], bus.V_in[8]};

  // Low 19 bits of the product of sign-extended operands equal the signed product.
  always_comb begin
    op   = dv_q;
    coef = C_RV;
    case (state_q)
      MUL1:    begin op = du_q; coef = C_GU; end
      MUL2:    begin op = dv_q; coef = C_GV; end
      MUL3:    begin op = du_q; coef = C_BU; end
      default: begin op = dv_q; coef = C_RV; end
    endcase
    op_ext   = {{10{op[8]}}, op};
    coef_ext = {{9{coef[9]}}, coef};
    prod     = op_ext * coef_ext;
    prod_ext = {prod[18], prod};
  end

  always_comb begin
    rnd_r  = acc_r_q + ROUND;
    rnd_g  = acc_g_q + ROUND;
    rnd_b  = acc_b_q + ROUND;
    term_r = 12'(rnd_r >>> FRAC);
    term_g = 12'(rnd_g >>> FRAC);
    term_b = 12'(rnd_b >>> FRAC);
    sum_r  = $signed({4'd0, y_q}) + term_r;
    sum_g  = $signed({4'd0, y_q}) - term_g;
    sum_b  = $signed({4'd0, y_q}) + term_b;
  end

  clamp_u8 u_clamp_r (.val(sum_r), .res(clamp_r));
  clamp_u8 u_clamp_g (.val(sum_g), .res(clamp_g));
  clamp_u8 u_clamp_b (.val(sum_b), .res(clamp_b));

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    du_d    = du_q;
    dv_d    = dv_q;
    acc_r_d = acc_r_q;
    acc_g_d = acc_g_q;
    acc_b_d = acc_b_q;
    out_r_d = out_r_q;
    out_g_d = out_g_q;
    out_b_d = out_b_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          y_d     = bus.Y_in[7:0];
          du_d    = {1'b0, bus.U_in[7:0]} - OFFSET;
          dv_d    = {1'b0, bus.V_in[7:0]} - OFFSET;
          state_d = MUL0;
        end
      end
      MUL0: begin acc_r_d = prod_ext;           state_d = MUL1; end
      MUL1: begin acc_g_d = prod_ext;           state_d = MUL2; end
      MUL2: begin acc_g_d = acc_g_q + prod_ext; state_d = MUL3; end
      MUL3: begin acc_b_d = prod_ext;           state_d = SAT;  end
      SAT: begin
        out_r_d = clamp_r;
        out_g_d = clamp_g;
        out_b_d = clamp_b;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      du_q    <= '0;
      dv_q    <= '0;
      acc_r_q <= '0;
      acc_g_q <= '0;
      acc_b_q <= '0;
      out_r_q <= '0;
      out_g_q <= '0;
      out_b_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      du_q    <= du_d;
      dv_q    <= dv_d;
      acc_r_q <= acc_r_d;
      acc_g_q <= acc_g_d;
      acc_b_q <= acc_b_d;
      out_r_q <= out_r_d;
      out_g_q <= out_g_d;
      out_b_q <= out_b_d;
      done_q  <= done_d;
    end
  end

  assign bus.done = done_q;
  assign bus.outR = out_r_q;
  assign bus.outG = out_g_q;
  assign bus.outB = out_b_q;

endmodule

// File: tb/tb_yuv2rgb.sv
// Directed bench for yuv2rgb with hand-computed BT.601 Q8 results.
module tb_yuv2rgb;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  yuv2rgb_if bus ();

  yuv2rgb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Launches one pixel, scrambles inputs after capture, checks latency and result.
  task automatic apply_stimulus(input string tag, input logic [7:0] y,
                                input logic [7:0] u, input logic [7:0] v,
                                input logic [8:0] er, input logic [8:0] eg,
                                input logic [8:0] eb, input bit pulse_mid);
    int n;
    int extra;
    @(negedge clk);
    bus.Y_in  = {1'b0, y};
    bus.U_in  = {1'b0, u};
    bus.V_in  = {1'b0, v};
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.Y_in  = 9'($urandom);
    bus.U_in  = 9'($urandom);
    bus.V_in  = 9'($urandom);
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (pulse_mid && n == 1) bus.start = 1'b1;
      if (n == 2) bus.start = 1'b0;
    end
    check_output({tag, "_latency"}, n, 5);
    check_output({tag, "_R"}, bus.outR, er);
    check_output({tag, "_G"}, bus.outG, eg);
    check_output({tag, "_B"}, bus.outB, eb);
    @(negedge clk);
    check_output({tag, "_done_pulse"}, bus.done, 1'b0);
    if (pulse_mid) begin
      extra = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (bus.done === 1'b1) extra++;
      end
      check_output({tag, "_no_extra"}, extra, 0);
      check_output({tag, "_hold_R"}, bus.outR, er);
    end
  endtask

  initial begin
    int pulses;
    int first;
    int last;
    int gap_bad;
    clk       = 1'b0;
    rst       = 1'b0;
    errors    = 0;
    checks    = 0;
    bus.start = 1'b0;
    bus.Y_in  = '0;
    bus.U_in  = '0;
    bus.V_in  = '0;

    repeat (2) @(negedge clk);
    check_output("rst_done", bus.done, 1'b0);
    check_output("rst_R", bus.outR, 9'd0);
    check_output("rst_G", bus.outG, 9'd0);
    check_output("rst_B", bus.outB, 9'd0);
    rst = 1'b1;

    apply_stimulus("grey",   8'd128, 8'd128, 8'd128, 9'd128, 9'd128, 9'd128, 1'b0);
    apply_stimulus("black",  8'd0,   8'd128, 8'd128, 9'd0,   9'd0,   9'd0,   1'b0);
    apply_stimulus("white",  8'd255, 8'd128, 8'd128, 9'd255, 9'd255, 9'd255, 1'b0);
    apply_stimulus("red",    8'd76,  8'd85,  8'd255, 9'd254, 9'd0,   9'd0,   1'b0);
    apply_stimulus("max",    8'd255, 8'd255, 8'd255, 9'd255, 9'd121, 9'd255, 1'b0);
    apply_stimulus("min",    8'd0,   8'd0,   8'd0,   9'd0,   9'd135, 9'd0,   1'b0);
    apply_stimulus("mixA",   8'd100, 8'd150, 8'd100, 9'd61,  9'd112, 9'd139, 1'b0);
    apply_stimulus("floorB", 8'd120, 8'd100, 8'd160, 9'd165, 9'd107, 9'd70,  1'b0);
    apply_stimulus("midpulse", 8'd100, 8'd150, 8'd100, 9'd61, 9'd112, 9'd139, 1'b1);

    // Back-to-back conversions with start held high.
    @(negedge clk);
    bus.Y_in  = 9'd128;
    bus.U_in  = 9'd128;
    bus.V_in  = 9'd128;
    bus.start = 1'b1;
    pulses  = 0;
    first   = -1;
    last    = -1;
    gap_bad = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (last >= 0 && (i - last) != 6) gap_bad++;
        if (first < 0) first = i;
        last = i;
        pulses++;
      end
    end
    bus.start = 1'b0;
    check_output("held_pulses", pulses, 5);
    check_output("held_first", first, 6);
    check_output("held_gap", gap_bad, 0);
    check_output("held_R", bus.outR, 9'd128);

    // Abort during MUL2: reset must clear outputs without a clock edge.
    @(negedge clk);
    bus.Y_in  = 9'd255;
    bus.U_in  = 9'd128;
    bus.V_in  = 9'd128;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("abort_done", bus.done, 1'b0);
    check_output("abort_R", bus.outR, 9'd0);
    check_output("abort_G", bus.outG, 9'd0);
    check_output("abort_B", bus.outB, 9'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    check_output("abort_no_done", pulses, 0);
    rst = 1'b1;
    apply_stimulus("after_rst", 8'd76, 8'd85, 8'd255, 9'd254, 9'd0, 9'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
